my_ip_temperatura_regs_slave: RTL and testbench

AXI4-Lite slave register file for the temperature IP, answering the master that sequentially writes and reads the four S00_AXI words.

- Holds four 32-bit registers:
  - reg0: control
  - reg1: alarm threshold
  - reg2: temperature / scratch
  - reg3: user
- Exposes the registers to the sensor logic.
- Optionally captures live temperature samples into reg2 and raises a threshold alarm.
- Sits between the AXI interconnect and the temperature sensing core.

---
 rtl/my_ip_temperatura_regs_slave.sv | 138 +++++++++++++
 tb/tb_my_ip_temperatura_regs_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/my_ip_temperatura_regs_slave.sv
// my_ip_temperatura_regs_slave: AXI4-Lite slave with four 32-bit registers for the temperature IP
// Ports: s00_axi_* AXI4-Lite slave (clock aclk, async active-low aresetn);
//   ctrl_out/thresh_out mirror reg0/reg1; temp_data/temp_valid sensor sample in;
//   temp_alarm registered threshold alarm out.
// Build option TEMP_CAPTURE_EN: reg2 becomes read-only and captures temp_data; alarm enabled.
module my_ip_temperatura_regs_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     ctrl_out,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     thresh_out,
  input  logic [15:0]                         temp_data,
  input  logic                                temp_valid,
  output logic                                temp_alarm
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  rd_state_t r_rd_state, w_rd_next;
  logic r_rdy, r_aw_held, r_w_held, r_bvalid;
  logic [1:0] r_aw_addr, w_addr;
  logic [DW-1:0] r_wdata, w_wdata, r_rdata;
  logic [SW-1:0] r_wstrb, w_wstrb;
  logic [DW-1:0] r_regs [4];
  logic w_aw_fire, w_w_fire, w_commit, w_wr_en, w_ar_fire, w_arready, w_rvalid, w_unused;
  // r_rdy keeps every ready low while in reset and lets them rise on the first edge after release
  assign s00_axi_awready = r_rdy & ~r_aw_held & ~r_bvalid;
  assign s00_axi_wready = r_rdy & ~r_w_held & ~r_bvalid;
  assign s00_axi_bvalid = r_bvalid;
  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign s00_axi_rdata = r_rdata;
  assign s00_axi_arready = w_arready;
  assign s00_axi_rvalid = w_rvalid;
  assign ctrl_out = r_regs[0];
  assign thresh_out = r_regs[1];
  assign w_aw_fire = s00_axi_awvalid & s00_axi_awready;
  assign w_w_fire = s00_axi_wvalid & s00_axi_wready;
  // A handshake on this edge counts as held, so AW+W together commit without an extra cycle
  assign w_commit = (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
  assign w_addr = r_aw_held ? r_aw_addr : s00_axi_awaddr[3:2];
  assign w_wdata = r_w_held ? r_wdata : s00_axi_wdata;
  assign w_wstrb = r_w_held ? r_wstrb : s00_axi_wstrb;
  assign w_ar_fire = w_arready & s00_axi_arvalid;
`ifdef TEMP_CAPTURE_EN
  logic r_alarm;
  assign w_wr_en = w_commit & (w_addr != 2'd2);
  assign temp_alarm = r_alarm;
  assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
  assign w_wr_en = w_commit;
  assign temp_alarm = 1'b0;
  assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0], temp_data, temp_valid};
`endif
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rdy <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held <= 1'b0;
      r_bvalid <= 1'b0;
      r_aw_addr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held <= 1'b0;
        r_bvalid <= 1'b1;
      end else begin
        if (w_aw_fire) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= s00_axi_awaddr[3:2];
        end
        if (w_w_fire) begin
          r_w_held <= 1'b1;
          r_wdata <= s00_axi_wdata;
          r_wstrb <= s00_axi_wstrb;
        end
        if (s00_axi_bready) r_bvalid <= 1'b0;
      end
    end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
`ifdef TEMP_CAPTURE_EN
      r_alarm <= 1'b0;
`endif
    end else begin
      if (w_wr_en)
        for (int k = 0; k < SW; k++)
          if (w_wstrb[k]) r_regs[w_addr][8*k +: 8] <= w_wdata[8*k +: 8];
`ifdef TEMP_CAPTURE_EN
      // Placed after the bus write so a coincident sample overrides it
      if (temp_valid) begin
        r_regs[2] <= {{(DW-16){1'b0}}, temp_data};
        r_alarm <= temp_data > r_regs[1][15:0];
      end
`endif
    end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rd_state <= RD_IDLE;
      r_rdata <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_ar_fire) r_rdata <= r_regs[s00_axi_araddr[3:2]];
    end
  end
  always_comb begin
    w_arready = r_rdy & (r_rd_state == RD_IDLE);
    w_rvalid = r_rd_state == RD_RESP;
    w_rd_next = w_ar_fire ? RD_RESP : (w_rvalid & s00_axi_rready) ? RD_IDLE : r_rd_state;
  end
endmodule

// File: tb/tb_my_ip_temperatura_regs_slave.sv
// tb_my_ip_temperatura_regs_slave: directed bench with read-data scoreboard for the register slave
module tb_my_ip_temperatura_regs_slave;
  logic clk, rst_n;
  logic [3:0] awaddr, araddr, wstrb;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ctrl_out, thresh_out;
  logic [1:0] bresp, rresp;
  logic [15:0] temp_data;
  logic temp_valid, temp_alarm;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  my_ip_temperatura_regs_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .ctrl_out(ctrl_out), .thresh_out(thresh_out),
    .temp_data(temp_data), .temp_valid(temp_valid), .temp_alarm(temp_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    chk("wr_ready_timeout", 32'(n < 20), 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    chk("wr_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("wr_bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    int n = 0;
    exp_q.push_back(exp);
    arvalid = 1'b1; araddr = a;
    while (!arready && n < 20) begin step(); n++; end
    chk("rd_ready_timeout", 32'(n < 20), 32'd1);
    step();
    arvalid = 1'b0;
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rresp", 32'(rresp), 32'd0);
    chk("rd_data", rdata, exp_q.pop_front());
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rd_rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wstrb = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; temp_data = '0; temp_valid = 0;
    repeat (3) step();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ctrl", ctrl_out, 32'd0);
    chk("rst_alarm", 32'(temp_alarm), 32'd0);
    rst_n = 1'b1;
    chk("rel_awready_early", 32'(awready), 32'd0);
    step();
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready", 32'(wready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'(i + 1));
    chk("ctrl_out", ctrl_out, 32'd1);
    chk("thresh_out", thresh_out, 32'd2);
    axi_read(4'h5, 32'd2);

    axi_write(4'h0, 32'hAABBCCDD, 4'hF);
    axi_write(4'h0, 32'h11223344, 4'b0101);
    axi_read(4'h0, 32'hAA22CC44);

    wvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready", 32'(wready), 32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    chk("wfirst_bvalid", 32'(bvalid), 32'd0);
    step();
    step();
    chk("wfirst_bvalid_wait", 32'(bvalid), 32'd0);
    awvalid = 1'b1; awaddr = 4'hC;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", 32'(bvalid), 32'd1);
      chk("bhold_awready", 32'(awready), 32'd0);
      chk("bhold_wready", 32'(wready), 32'd0);
      if (i < 4) step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bhs_bvalid", 32'(bvalid), 32'd0);
    chk("bhs_awready", 32'(awready), 32'd1);
    chk("bhs_wready", 32'(wready), 32'd1);
    axi_read(4'hC, 32'h5A5A5A5A);
    chk("wfirst_ctrl_keep", ctrl_out, 32'hAA22CC44);

    chk("same_arready", 32'(arready & awready & wready), 32'd1);
    exp_q.push_back(32'd2);
    awvalid = 1'b1; awaddr = 4'h4; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 4'h4;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_bvalid", 32'(bvalid), 32'd1);
    chk("same_rvalid", 32'(rvalid), 32'd1);
    chk("same_rdata_old", rdata, exp_q.pop_front());
    chk("same_thresh", thresh_out, 32'h77);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    chk("same_done", 32'(bvalid | rvalid), 32'd0);
    axi_read(4'h4, 32'h77);

`ifdef TEMP_CAPTURE_EN
    axi_write(4'h4, 32'h50, 4'hF);
    temp_data = 16'h0051; temp_valid = 1'b1;
    step();
    temp_valid = 1'b0;
    chk("cap_alarm_hi", 32'(temp_alarm), 32'd1);
    axi_write(4'h8, 32'hFFFF, 4'hF);
    axi_read(4'h8, 32'h51);
    chk("cap_alarm_hold", 32'(temp_alarm), 32'd1);
    temp_data = 16'h0050; temp_valid = 1'b1;
    step();
    temp_valid = 1'b0;
    chk("cap_alarm_lo", 32'(temp_alarm), 32'd0);
    axi_read(4'h8, 32'h50);
`else
    axi_write(4'h8, 32'hFFFF, 4'hF);
    temp_data = 16'h1234; temp_valid = 1'b1;
    step();
    temp_valid = 1'b0;
    step();
    chk("nocap_alarm", 32'(temp_alarm), 32'd0);
    axi_read(4'h8, 32'hFFFF);
`endif

    exp_q.push_back(32'hAA22CC44);
    awvalid = 1'b1; awaddr = 4'h0; wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 4'h0;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("mid_bvalid", 32'(bvalid), 32'd1);
    chk("mid_rvalid", 32'(rvalid), 32'd1);
    chk("mid_rdata", rdata, exp_q.pop_front());
    chk("mid_ctrl", ctrl_out, 32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ares_bvalid", 32'(bvalid), 32'd0);
    chk("ares_rvalid", 32'(rvalid), 32'd0);
    chk("ares_rdata", rdata, 32'd0);
    chk("ares_ctrl", ctrl_out, 32'd0);
    chk("ares_thresh", thresh_out, 32'd0);
    chk("ares_ready", 32'(awready | wready | arready), 32'd0);
    chk("ares_alarm", 32'(temp_alarm), 32'd0);
    step();
    rst_n = 1'b1;
    chk("rel2_awready_early", 32'(awready), 32'd0);
    step();
    chk("rel2_ready", 32'(awready & wready & arready), 32'd1);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
